// File: rtl/rvga_types_pkg.sv
// Shared types for the execute stage: ALU/branch opcodes, the control word
// that travels down the pipe, and the multiplier FSM states.
package rvga_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } rvga_alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LT   = 3'd2,
        BR_GE   = 3'd3,
        BR_LTU  = 3'd4,
        BR_GEU  = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } rvga_br_op_e;

    // v marks a real instruction so that an ADD with all-zero fields is never
    // mistaken for a bubble; an all-zero word is a bubble.
    typedef struct packed {
        logic         v;
        logic         mul_v;
        logic         br_v;
        rvga_br_op_e  br_op;
        rvga_alu_op_e alu_op;
        logic         src2_imm_v;
    } rvga_cword_s;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } rvga_mul_state_e;

endpackage

// File: rtl/dff.sv
// Plain enable flop with synchronous active-high clear.
module dff #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               w_v_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)      r_q <= '0;
        else if (w_v_i) r_q <= data_i;
    end

    assign data_o = r_q;

endmodule

// File: rtl/exe_stage_mul.sv
// Iterative shift-add multiplier: one IDLE (load) cycle, width_p iteration
// cycles, then DONE holding the low product bits until released.
module mul_iter
    import rvga_types::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               hold_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [width_p-1:0] p_o
);

    localparam int CW = $clog2(width_p);

    rvga_mul_state_e    r_state, w_next;
    logic [width_p-1:0] r_acc, r_mcand, r_mplier;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= MUL_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            MUL_IDLE: if (start_i) w_next = MUL_BUSY;
            MUL_BUSY: if (r_cnt == CW'(width_p - 1)) w_next = MUL_DONE;
            MUL_DONE: if (!hold_i) w_next = MUL_IDLE;
            default:  w_next = MUL_IDLE;
        endcase
    end

    // Busy covers the load cycle too, so it only depends on state and start.
    always_comb begin
        busy_o = (r_state == MUL_BUSY) || (r_state == MUL_IDLE && start_i);
        done_o = (r_state == MUL_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                MUL_IDLE: if (start_i) begin
                    r_acc    <= '0;
                    r_mcand  <= a_i;
                    r_mplier <= b_i;
                    r_cnt    <= '0;
                end
                MUL_BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign p_o = r_acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers the incoming word, then produces ALU, branch and
// link results combinationally; MUL runs on the iterative unit and stalls.
module exe_stage
    import rvga_types::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_v_i,
    input  rvga_cword_s        cword_i,
    input  logic [width_p-1:0] pc_i,
    input  logic [width_p-1:0] rs1_data_i,
    input  logic [width_p-1:0] rs2_data_i,
    input  logic [width_p-1:0] imm_data_i,
    output rvga_cword_s        cword_o,
    output logic [width_p-1:0] result_o,
    output logic [width_p-1:0] store_data_o,
    output logic               br_v_o,
    output logic [width_p-1:0] br_tgt_o,
    output logic               stall_v_o
);

    localparam int SHW = $clog2(width_p);

    rvga_cword_s        r_cword;
    logic [width_p-1:0] r_pc, r_rs1, r_rs2, r_imm;
    logic               w_load, w_busy, w_done, w_cond, w_link;
    logic [width_p-1:0] w_b, w_alu, w_prod;
    logic [SHW-1:0]     w_shamt;

    assign w_load = !stall_v_i && !w_busy;

    dff #(.width_p($bits(rvga_cword_s))) u_cword (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(w_load), .data_i(cword_i), .data_o(r_cword));
    dff #(.width_p(width_p)) u_pc (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(w_load), .data_i(pc_i), .data_o(r_pc));
    dff #(.width_p(width_p)) u_rs1 (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(w_load), .data_i(rs1_data_i), .data_o(r_rs1));
    dff #(.width_p(width_p)) u_rs2 (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(w_load), .data_i(rs2_data_i), .data_o(r_rs2));
    dff #(.width_p(width_p)) u_imm (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(w_load), .data_i(imm_data_i), .data_o(r_imm));

    mul_iter #(.width_p(width_p)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (r_cword.mul_v),
        .hold_i  (stall_v_i),
        .a_i     (r_rs1),
        .b_i     (r_rs2),
        .busy_o  (w_busy),
        .done_o  (w_done),
        .p_o     (w_prod)
    );

    assign w_b     = r_cword.src2_imm_v ? r_imm : r_rs2;
    assign w_shamt = w_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        unique case (r_cword.alu_op)
            ALU_ADD:  w_alu = r_rs1 + w_b;
            ALU_SUB:  w_alu = r_rs1 - w_b;
            ALU_SLL:  w_alu = r_rs1 << w_shamt;
            ALU_SLT:  w_alu = width_p'($signed(r_rs1) < $signed(w_b));
            ALU_SLTU: w_alu = width_p'(r_rs1 < w_b);
            ALU_XOR:  w_alu = r_rs1 ^ w_b;
            ALU_SRL:  w_alu = r_rs1 >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(r_rs1) >>> w_shamt);
            ALU_OR:   w_alu = r_rs1 | w_b;
            ALU_AND:  w_alu = r_rs1 & w_b;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        unique case (r_cword.br_op)
            BR_EQ:   w_cond = (r_rs1 == r_rs2);
            BR_NE:   w_cond = (r_rs1 != r_rs2);
            BR_LT:   w_cond = ($signed(r_rs1) < $signed(r_rs2));
            BR_GE:   w_cond = ($signed(r_rs1) >= $signed(r_rs2));
            BR_LTU:  w_cond = (r_rs1 < r_rs2);
            BR_GEU:  w_cond = (r_rs1 >= r_rs2);
            BR_JAL:  w_cond = 1'b1;
            BR_JALR: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_link = r_cword.br_v && (r_cword.br_op == BR_JAL || r_cword.br_op == BR_JALR);

    // Outputs depend only on registered state, never on stall_v_i.
    always_comb begin
        cword_o      = w_busy ? '0 : r_cword;
        stall_v_o    = w_busy;
        br_v_o       = r_cword.br_v && w_cond && !w_busy;
        br_tgt_o     = (r_cword.br_op == BR_JALR) ? ((r_rs1 + r_imm) & ~width_p'(1))
                                                  : (r_pc + r_imm);
        store_data_o = r_rs2;
        if (w_done)      result_o = w_prod;
        else if (w_link) result_o = r_pc + width_p'(4);
        else             result_o = w_alu;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a cycle-level reference model and
// hand-computed spot checks.
module tb_exe_stage;
    import rvga_types::*;

    localparam int MUL_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    rvga_cword_s cword_i = '0;
    logic [31:0] pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
    rvga_cword_s cword_o;
    logic [31:0] result_o, store_o, tgt_o;
    logic        br_v_o, stall_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    exe_stage #(.width_p(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_v_i    (stall_i),
        .cword_i      (cword_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_i),
        .rs2_data_i   (rs2_i),
        .imm_data_i   (imm_i),
        .cword_o      (cword_o),
        .result_o     (result_o),
        .store_data_o (store_o),
        .br_v_o       (br_v_o),
        .br_tgt_o     (tgt_o),
        .stall_v_o    (stall_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rvga_cword_s mk(input logic mul, input logic br, input rvga_br_op_e bop,
                                       input rvga_alu_op_e aop, input logic simm);
        rvga_cword_s c;
        c = '0;
        c.v = 1'b1; c.mul_v = mul; c.br_v = br; c.br_op = bop; c.alu_op = aop; c.src2_imm_v = simm;
        return c;
    endfunction

    function automatic logic [31:0] f_alu(input rvga_alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic f_cond(input rvga_br_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b1;
        endcase
    endfunction

    // Reference model: the registered word plus the number of cycles it has
    // been resident; a MUL word stalls for MUL_LAT cycles then shows a*b.
    rvga_cword_s m_cw = '0;
    logic [31:0] m_pc = '0, m_rs1 = '0, m_rs2 = '0, m_imm = '0;
    int          m_cyc = 0;
    logic        m_stall;
    assign m_stall = m_cw.mul_v && (m_cyc < MUL_LAT);

    always @(posedge clk) begin
        if (rst) begin
            m_cw <= '0; m_pc <= '0; m_rs1 <= '0; m_rs2 <= '0; m_imm <= '0; m_cyc <= 0;
        end else if (!stall_i && !m_stall) begin
            m_cw <= cword_i; m_pc <= pc_i; m_rs1 <= rs1_i; m_rs2 <= rs2_i; m_imm <= imm_i;
            m_cyc <= 0;
        end else if (m_stall) begin
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] er, et;
            if (m_cw.mul_v)
                er = m_rs1 * m_rs2;
            else if (m_cw.br_v && (m_cw.br_op == BR_JAL || m_cw.br_op == BR_JALR))
                er = m_pc + 32'd4;
            else
                er = f_alu(m_cw.alu_op, m_rs1, m_cw.src2_imm_v ? m_imm : m_rs2);
            et = (m_cw.br_op == BR_JALR) ? ((m_rs1 + m_imm) & 32'hFFFF_FFFE) : (m_pc + m_imm);
            chk("m_cword", 32'(cword_o), m_stall ? 32'h0 : 32'(m_cw));
            chk("m_stall", 32'(stall_o), 32'(m_stall));
            chk("m_br_v", 32'(br_v_o), 32'(!m_stall && m_cw.br_v && f_cond(m_cw.br_op, m_rs1, m_rs2)));
            chk("m_store", store_o, m_rs2);
            if (!m_stall && m_cw.v) chk("m_result", result_o, er);
            if (m_cw.br_v) chk("m_br_tgt", tgt_o, et);
        end
    end

    // Called at a negedge; returns at the negedge after the word is registered.
    task automatic issue(input rvga_cword_s c, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        cword_i = c; pc_i = pc; rs1_i = a; rs2_i = b; imm_i = imm;
        @(negedge clk);
    endtask

    task automatic alu_case(input string name, input rvga_alu_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        issue(mk(0, 0, BR_EQ, op, 0), 32'h0, a, b, 32'h0);
        chk(name, result_o, exp);
    endtask

    task automatic wait_mul(input string name);
        int n;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, MUL_LAT);
    endtask

    initial begin
        rvga_cword_s mulc, addc;
        repeat (2) @(negedge clk);
        chk("rst_cword", 32'(cword_o), 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_store", store_o, 32'h0);
        chk("rst_br_v", 32'(br_v_o), 32'h0);
        chk("rst_tgt", tgt_o, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue(mk(0, 0, BR_EQ, ALU_ADD, 1), 32'h0, 32'd5, 32'h0, 32'hFFFF_FFF9);
        chk("addi_result", result_o, 32'hFFFF_FFFE);
        chk("addi_stall", 32'(stall_o), 32'h0);

        issue(mk(0, 1, BR_LT, ALU_ADD, 0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        chk("blt_br_v", 32'(br_v_o), 32'h1);
        chk("blt_tgt", tgt_o, 32'h120);
        issue(mk(0, 1, BR_LTU, ALU_ADD, 0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        chk("bltu_br_v", 32'(br_v_o), 32'h0);
        issue(mk(0, 1, BR_JALR, ALU_ADD, 0), 32'h40, 32'h1003, 32'h0, 32'd4);
        chk("jalr_tgt", tgt_o, 32'h1006);
        chk("jalr_result", result_o, 32'h44);
        chk("jalr_br_v", 32'(br_v_o), 32'h1);
        issue(mk(0, 1, BR_JAL, ALU_ADD, 0), 32'h200, 32'h0, 32'h0, 32'hFFFF_FFF0);
        chk("jal_tgt", tgt_o, 32'h1F0);
        chk("jal_result", result_o, 32'h204);
        issue(mk(0, 1, BR_GE, ALU_ADD, 0), 32'h10, 32'd7, 32'd7, 32'h8);
        chk("bge_eq_br_v", 32'(br_v_o), 32'h1);

        alu_case("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'h1);
        alu_case("sub", ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
        alu_case("sll_mask", ALU_SLL, 32'd1, 32'h3F, 32'h8000_0000);
        alu_case("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_case("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_case("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1);
        alu_case("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0);
        alu_case("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu_case("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu_case("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);

        // MUL 0xFFFFFFFF * 3, with the following word waiting upstream.
        mulc = mk(1, 0, BR_EQ, ALU_ADD, 0);
        addc = mk(0, 0, BR_EQ, ALU_ADD, 0);
        issue(mulc, 32'h0, 32'hFFFF_FFFF, 32'd3, 32'h0);
        cword_i = addc; rs1_i = 32'd1; rs2_i = 32'd2;
        wait_mul("mul1_stall_cycles");
        chk("mul1_result", result_o, 32'hFFFF_FFFD);
        chk("mul1_cword", 32'(cword_o), 32'(mulc));
        @(negedge clk);
        chk("after_mul1_result", result_o, 32'd3);

        // MUL finishing under downstream stall; result must hold.
        issue(mulc, 32'h0, 32'd7, 32'd6, 32'h0);
        stall_i = 1'b1;
        cword_i = addc; rs1_i = 32'd10; rs2_i = 32'd20;
        wait_mul("mul2_stall_cycles");
        repeat (5) begin
            chk("mul2_hold_result", result_o, 32'd42);
            chk("mul2_hold_cword", 32'(cword_o), 32'(mulc));
            @(negedge clk);
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("mul2_next_result", result_o, 32'd30);
        chk("mul2_next_cword", 32'(cword_o), 32'(addc));

        // Reset in the middle of a multiply.
        issue(mulc, 32'h0, 32'd5, 32'd9, 32'h0);
        cword_i = '0;
        repeat (11) @(negedge clk);
        chk("mid_mul_stall", 32'(stall_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cword", 32'(cword_o), 32'h0);
        chk("abort_stall", 32'(stall_o), 32'h0);
        chk("abort_br_v", 32'(br_v_o), 32'h0);
        chk("abort_result", result_o, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
